// File: rtl/bitcoin_nonce_search.sv
// rtl/bitcoin_nonce_search.sv - SHA-256d nonce sweep/search engine over a header held in external memory
// One shared 66-cycle compression datapath is reused for the midstate, per-nonce and final blocks.
module bitcoin_nonce_search #(
    parameter int NUM_NONCES = 16,
    parameter int MEM_AW     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              search_mode,
    input  logic [31:0]       nonce_base,
    input  logic [31:0]       target,
    input  logic [MEM_AW-1:0] message_addr,
    input  logic [MEM_AW-1:0] output_addr,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [31:0]       found_nonce,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MID   = 3'd2;
    localparam logic [2:0] S_NONCE = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int         IW      = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
    localparam int         RES_N   = 1 << IW;
    localparam logic [8:0] LAST_N  = 9'(NUM_NONCES - 1);
    localparam logic [8:0] SWEEP_W = 9'(NUM_NONCES);

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [2:0]        state_q, state_d;
    logic [8:0]        cnt_q, cnt_d, n_q, n_d, num_wr_q, num_wr_d;
    logic              mode_q, mode_d, found_q, found_d;
    logic [31:0]       nonce_base_q, nonce_base_d, target_q, target_d;
    logic [31:0]       found_nonce_q, found_nonce_d, hit_h0_q, hit_h0_d;
    logic [MEM_AW-1:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0]       hdr_q [19], hdr_d [19];
    logic [31:0]       mid_q [8], mid_d [8], h1_q [8], h1_d [8], st_q [8], st_d [8];
    logic [31:0]       w_q [16], w_d [16];
    logic [31:0]       res_q [RES_N], res_d [RES_N];

    logic [31:0] cur_init [8], cur_blk [16], digest [8];
    logic [31:0] nonce_cur, t1, t2, w_next, h0;
    logic [5:0]  rnd;
    logic        hit;

    assign nonce_cur = nonce_base_q + {23'd0, n_q};

    // Round t uses W_t = w_q[0]; the window slides one word per round.
    always_comb begin
        rnd    = 6'(cnt_q - 9'd1);
        t1     = st_q[7] + (rotr(st_q[4], 6) ^ rotr(st_q[4], 11) ^ rotr(st_q[4], 25))
               + ((st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6])) + K[rnd] + w_q[0];
        t2     = (rotr(st_q[0], 2) ^ rotr(st_q[0], 13) ^ rotr(st_q[0], 22))
               + ((st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]));
        w_next = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
               + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    always_comb begin
        for (int i = 0; i < 8; i++) cur_init[i] = (state_q == S_NONCE) ? mid_q[i] : IV[i];
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
        case (state_q)
            S_MID: for (int i = 0; i < 16; i++) cur_blk[i] = hdr_q[i];
            S_NONCE: begin
                cur_blk[0]  = hdr_q[16];
                cur_blk[1]  = hdr_q[17];
                cur_blk[2]  = hdr_q[18];
                cur_blk[3]  = nonce_cur;
                cur_blk[4]  = 32'h80000000;
                cur_blk[15] = 32'h00000280;
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) cur_blk[i] = h1_q[i];
                cur_blk[8]  = 32'h80000000;
                cur_blk[15] = 32'h00000100;
            end
            default: ;
        endcase
        for (int i = 0; i < 8; i++) digest[i] = cur_init[i] + st_q[i];
    end

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  n_d = n_q;  num_wr_d = num_wr_q;
        mode_d = mode_q;  found_d = found_q;  found_nonce_d = found_nonce_q;
        nonce_base_d = nonce_base_q;  target_d = target_q;  hit_h0_d = hit_h0_q;
        msg_addr_d = msg_addr_q;  out_addr_d = out_addr_q;
        hdr_d = hdr_q;  mid_d = mid_q;  h1_d = h1_q;  st_d = st_q;  w_d = w_q;  res_d = res_q;
        h0  = digest[0];
        hit = mode_q && (digest[0] <= target_q);
        case (state_q)
            S_IDLE: if (start) begin
                mode_d = search_mode;  nonce_base_d = nonce_base;  target_d = target;
                msg_addr_d = message_addr;  out_addr_d = output_addr;
                found_d = 1'b0;  found_nonce_d = 32'h0;  cnt_d = 9'd0;  n_d = 9'd0;
                state_d = S_READ;
            end
            S_READ: begin
                // Word i arrives one cycle after its address, so capture lags by one.
                if (cnt_q != 9'd0) hdr_d[5'(cnt_q - 9'd1)] = mem_read_data;
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == 9'd19) begin
                    cnt_d   = 9'd0;
                    state_d = S_MID;
                end
            end
            S_MID, S_NONCE, S_FINAL: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == 9'd0) begin
                    st_d = cur_init;
                    w_d  = cur_blk;
                end else if (cnt_q <= 9'd64) begin
                    st_d[7] = st_q[6];  st_d[6] = st_q[5];  st_d[5] = st_q[4];  st_d[4] = st_q[3] + t1;
                    st_d[3] = st_q[2];  st_d[2] = st_q[1];  st_d[1] = st_q[0];  st_d[0] = t1 + t2;
                    for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                    w_d[15] = w_next;
                end else begin
                    cnt_d = 9'd0;
                    if (state_q == S_MID) begin
                        mid_d   = digest;
                        state_d = S_NONCE;
                    end else if (state_q == S_NONCE) begin
                        h1_d    = digest;
                        state_d = S_FINAL;
                    end else begin
                        if (!mode_q) res_d[n_q[IW-1:0]] = h0;
                        if (hit) begin
                            found_d = 1'b1;  found_nonce_d = nonce_cur;  hit_h0_d = h0;
                        end
                        if (hit || n_q == LAST_N) begin
                            num_wr_d = mode_q ? (hit ? 9'd2 : 9'd0) : SWEEP_W;
                            state_d  = S_WRITE;
                        end else begin
                            n_d     = n_q + 9'd1;
                            state_d = S_NONCE;
                        end
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == num_wr_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;  cnt_q <= '0;  n_q <= '0;  num_wr_q <= '0;
            mode_q <= 1'b0;  found_q <= 1'b0;  found_nonce_q <= '0;  hit_h0_q <= '0;
            nonce_base_q <= '0;  target_q <= '0;  msg_addr_q <= '0;  out_addr_q <= '0;
            hdr_q <= '{default: '0};  mid_q <= '{default: '0};  h1_q <= '{default: '0};
            st_q <= '{default: '0};  w_q <= '{default: '0};  res_q <= '{default: '0};
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  n_q <= n_d;  num_wr_q <= num_wr_d;
            mode_q <= mode_d;  found_q <= found_d;  found_nonce_q <= found_nonce_d;  hit_h0_q <= hit_h0_d;
            nonce_base_q <= nonce_base_d;  target_q <= target_d;  msg_addr_q <= msg_addr_d;  out_addr_q <= out_addr_d;
            hdr_q <= hdr_d;  mid_q <= mid_d;  h1_q <= h1_d;  st_q <= st_d;  w_q <= w_d;  res_q <= res_d;
        end
    end

    assign mem_clk     = clk;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign found       = found_q;
    assign found_nonce = found_nonce_q;

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = 32'h0;
        if (state_q == S_READ && cnt_q < 9'd19) begin
            mem_addr = msg_addr_q + MEM_AW'(cnt_q);
        end else if (state_q == S_WRITE && cnt_q < num_wr_q) begin
            mem_we         = 1'b1;
            mem_addr       = out_addr_q + MEM_AW'(cnt_q);
            mem_write_data = !mode_q ? res_q[cnt_q[IW-1:0]] : ((cnt_q == 9'd0) ? found_nonce_q : hit_h0_q);
        end
    end
endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// tb/tb_bitcoin_nonce_search.sv - randomized self-checking bench against a SHA-256d reference model
module tb_bitcoin_nonce_search;
    localparam int NN = 16;
    localparam int AW = 16;
    localparam logic [255:0] IV_T = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:63][31:0] KT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, search_mode = 1'b0;
    logic [31:0]   nonce_base = 32'h0, target = 32'h0;
    logic [AW-1:0] message_addr = '0, output_addr = '0;
    logic          busy, done, found, mem_clk, mem_we;
    logic [31:0]   found_nonce, mem_write_data, mem_read_data;
    logic [AW-1:0] mem_addr;

    bitcoin_nonce_search #(.NUM_NONCES(NN), .MEM_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .search_mode(search_mode),
        .nonce_base(nonce_base), .target(target), .message_addr(message_addr),
        .output_addr(output_addr), .busy(busy), .done(done), .found(found),
        .found_nonce(found_nonce), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

    always #5 clk = ~clk;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   hdr [19];
    int            cyc = 0, n_cmp = 0, n_fail = 0, done_cnt = 0, busy_gap = 0;
    bit            running = 1'b0;
    logic [AW-1:0] wa [$];
    logic [31:0]   wd [$];
    int            wc [$];

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        mem_read_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_write_data);
            wc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (running && !done && !busy) busy_gap++;
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    // Double SHA-256 of the 80-byte header with the nonce as word 3 of the second block.
    function automatic logic [31:0] model_h0(input logic [31:0] nonce);
        logic [511:0] b1, b2, b3;
        logic [255:0] s1, s2, s3;
        for (int i = 0; i < 16; i++) b1[511-32*i -: 32] = hdr[i];
        b2 = {hdr[16], hdr[17], hdr[18], nonce, 32'h80000000, 320'd0, 32'h00000280};
        s1 = compress(IV_T, b1);
        s2 = compress(s1, b2);
        b3 = {s2, 32'h80000000, 192'd0, 32'h00000100};
        s3 = compress(IV_T, b3);
        return s3[255:224];
    endfunction

    task automatic set_hdr(input bit rnd);
        for (int i = 0; i < 19; i++) hdr[i] = rnd ? $urandom : 32'h01234567 + 32'(i);
    endtask

    task automatic do_run(input logic mode, input logic [31:0] base, input logic [31:0] tgt,
                          input logic [AW-1:0] ma, input logic [AW-1:0] oa, input bit disturb,
                          input int abort_at, output int lat, output bit timeout,
                          output int wbase, output int dbase);
        int t0;
        for (int i = 0; i < 19; i++) mem[AW'(ma + AW'(i))] = hdr[i];
        @(negedge clk);
        search_mode = mode; nonce_base = base; target = tgt;
        message_addr = ma; output_addr = oa; start = 1'b1;
        t0 = cyc; wbase = wa.size(); dbase = done_cnt;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            search_mode = ~mode; nonce_base = $urandom; target = $urandom;
            message_addr = AW'($urandom); output_addr = AW'($urandom);
        end
        running = 1'b1; timeout = 1'b1; lat = 0;
        for (int c = 1; c < 3000; c++) begin
            if (abort_at != 0 && cyc - t0 == abort_at) begin
                reset_n = 1'b0; running = 1'b0; timeout = 1'b0;
                #1;
                return;
            end
            if (done) begin
                lat = cyc - t0; timeout = 1'b0;
                break;
            end
            start = (disturb && c == 50);
            @(negedge clk);
        end
        running = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] got [8];
        string nm [8];
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        got = '{32'(busy), 32'(done), 32'(found), found_nonce, 32'(mem_we), 32'(mem_addr), mem_write_data, 32'(busy_gap)};
        nm  = '{"rst_busy", "rst_done", "rst_found", "rst_found_nonce", "rst_mem_we", "rst_mem_addr", "rst_wdata", "rst_busy_gap"};
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 32'h0) begin n_fail++; $display("FAIL %s: got %0h want 0", nm[i], got[i]); end
        end
        @(posedge clk); #2 reset_n = 1'b1;
    endtask

    task automatic test_sweep_run(input string name, input logic [31:0] base, input bit disturb);
        int lat, wb, db, exp_lat;
        bit to;
        logic [AW-1:0] ma, oa;
        logic [31:0] exp;
        ma = AW'($urandom); oa = AW'($urandom);
        exp_lat = 20 + 66 + 132*NN + NN + 2;
        do_run(1'b0, base, $urandom, ma, oa, disturb, 0, lat, to, wb, db);
        n_cmp++; if (to) begin n_fail++; $display("FAIL %s timeout: no done within bound", name); end
        n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
        n_cmp++; if (wa.size() - wb !== NN) begin n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, wa.size() - wb, NN); end
        for (int i = 0; i < NN; i++) begin
            if (wb + i < wa.size()) begin
                exp = model_h0(base + 32'(i));
                n_cmp++;
                if (wa[wb+i] !== AW'(oa + AW'(i)) || wd[wb+i] !== exp || wc[wb+i] !== wc[wb] + i) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: got addr %0h data %0h cyc+%0d want addr %0h data %0h cyc+%0d",
                             name, i, wa[wb+i], wd[wb+i], wc[wb+i] - wc[wb], AW'(oa + AW'(i)), exp, i);
                end
            end
        end
        n_cmp++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - db); end
        n_cmp++; if (found !== 1'b0) begin n_fail++; $display("FAIL %s found: got %0b want 0", name, found); end
        n_cmp++; if (found_nonce !== 32'h0) begin n_fail++; $display("FAIL %s found_nonce: got %0h want 0", name, found_nonce); end
        n_cmp++; if (busy_gap !== 0) begin n_fail++; $display("FAIL %s busy_gap: got %0d want 0", name, busy_gap); end
    endtask

    task automatic test_search(input string name, input int kind);
        int lat, wb, db, k, w, hn, exp_lat;
        bit to, hit;
        logic [AW-1:0] ma, oa;
        logic [31:0] base, tgt, h, hh, exp_fn;
        set_hdr(kind == 2);
        base = $urandom; ma = AW'($urandom); oa = AW'($urandom);
        tgt = (kind == 0) ? 32'hFFFFFFFF : (kind == 1) ? 32'h0 : model_h0(base + $urandom_range(NN - 1));
        hit = 1'b0; hn = 0; hh = 32'h0;
        for (int n = 0; n < NN; n++) begin
            h = model_h0(base + 32'(n));
            if (!hit && h <= tgt) begin hit = 1'b1; hn = n; hh = h; end
        end
        k = hit ? hn + 1 : NN;
        w = hit ? 2 : 0;
        exp_fn = hit ? base + 32'(hn) : 32'h0;
        exp_lat = 20 + 66 + 132*k + w + 2;
        do_run(1'b1, base, tgt, ma, oa, 1'b0, 0, lat, to, wb, db);
        n_cmp++; if (to) begin n_fail++; $display("FAIL %s timeout: no done within bound", name); end
        n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
        n_cmp++; if (wa.size() - wb !== w) begin n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, wa.size() - wb, w); end
        if (hit && wa.size() - wb == 2) begin
            n_cmp++;
            if (wa[wb] !== oa || wd[wb] !== exp_fn || wa[wb+1] !== AW'(oa + 1'b1) || wd[wb+1] !== hh) begin
                n_fail++;
                $display("FAIL %s hit_writes: got %0h:%0h %0h:%0h want %0h:%0h %0h:%0h",
                         name, wa[wb], wd[wb], wa[wb+1], wd[wb+1], oa, exp_fn, AW'(oa + 1'b1), hh);
            end
        end
        n_cmp++; if (found !== hit) begin n_fail++; $display("FAIL %s found: got %0b want %0b", name, found, hit); end
        n_cmp++; if (found_nonce !== exp_fn) begin n_fail++; $display("FAIL %s found_nonce: got %0h want %0h", name, found_nonce, exp_fn); end
        n_cmp++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - db); end
    endtask

    task automatic test_reset_mid_run();
        int lat, wb, db;
        bit to;
        logic [31:0] got [7];
        string nm [7];
        set_hdr(1'b0);
        do_run(1'b0, 32'h0, 32'h0, AW'($urandom), AW'($urandom), 1'b0, 86 + 132*3 + 20, lat, to, wb, db);
        got = '{32'(busy), 32'(done), 32'(found), found_nonce, 32'(mem_we), 32'(mem_addr), mem_write_data};
        nm  = '{"abort_busy", "abort_done", "abort_found", "abort_found_nonce", "abort_mem_we", "abort_mem_addr", "abort_wdata"};
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (got[i] !== 32'h0) begin n_fail++; $display("FAIL %s: got %0h want 0", nm[i], got[i]); end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (wa.size() !== wb) begin n_fail++; $display("FAIL abort_stray_writes: got %0d want 0", wa.size() - wb); end
        @(posedge clk); #2 reset_n = 1'b1;
        test_sweep_run("rerun_after_reset", 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        set_hdr(1'b0); test_sweep_run("sweep", 32'h0, 1'b0);
        test_search("search_hit_first", 0);
        test_search("search_miss", 1);
        test_search("search_rand_a", 2);
        test_search("search_rand_b", 2);
        set_hdr(1'b1); test_sweep_run("sweep_wrap", 32'hFFFFFFFE, 1'b0);
        test_reset_mid_run();
        set_hdr(1'b1); test_sweep_run("start_while_busy", $urandom, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
